// File: rtl/satd_job_sched_pkg.sv
// Shared definitions for the SATD job scheduler: state codes, control-word
// bit positions and the control-word decode used by the output registers.
package satd_job_sched_pkg;

  localparam int PHASE_LEN_DEF = 4;
  localparam int OS_W          = 10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HT   = 3'd2,
    ST_VT   = 3'd3,
    ST_ACC  = 3'd4
  } state_t;

  localparam int OS_ROW_LO  = 0;
  localparam int OS_ROW_HI  = 1;
  localparam int OS_LD_EN   = 2;
  localparam int OS_H_EN    = 3;
  localparam int OS_V_EN    = 4;
  localparam int OS_ACC_EN  = 5;
  localparam int OS_ACC_CLR = 6;
  localparam int OS_RES_LD  = 7;
  localparam int OS_BUSY    = 8;
  localparam int OS_DONE    = 9;

  // Datapath control word for a given (state, phase count) pair.
  function automatic logic [OS_W-1:0] ctrl_word(input state_t st, input logic [2:0] cnt);
    logic [OS_W-1:0] w;
    w = '0;
    case (st)
      ST_LOAD: begin
        w[OS_ROW_HI:OS_ROW_LO] = cnt[1:0];
        w[OS_LD_EN]            = 1'b1;
        w[OS_ACC_CLR]          = (cnt == 3'd0);
        w[OS_BUSY]             = 1'b1;
      end
      ST_HT: begin
        w[OS_ROW_HI:OS_ROW_LO] = cnt[1:0];
        w[OS_H_EN]             = 1'b1;
        w[OS_BUSY]             = 1'b1;
      end
      ST_VT: begin
        w[OS_ROW_HI:OS_ROW_LO] = cnt[1:0];
        w[OS_V_EN]             = 1'b1;
        w[OS_ACC_EN]           = 1'b1;
        w[OS_BUSY]             = 1'b1;
      end
      ST_ACC: begin
        w[OS_RES_LD] = 1'b1;
        w[OS_BUSY]   = 1'b1;
        w[OS_DONE]   = 1'b1;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/satd_job_sched_if.sv
// Requester/scheduler bundle: job requests in, grant, control word and
// debug status out.
interface satd_job_sched_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic [9:0]       out_signal;
  logic [2:0]       state;
  logic [2:0]       count;
  logic             busy;
  logic             done;

  modport master (
    output req,
    input  grant, grant_id, out_signal, state, count, busy, done
  );

  modport slave (
    input  req,
    output grant, grant_id, out_signal, state, count, busy, done
  );
endinterface

// File: rtl/satd_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after
// ptr (wrapping) wins.
module satd_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  id,
  output logic             any
);

  logic [N_REQ-1:0] rot_req;
  logic [ID_W-1:0]  off;
  logic             found;

  always_comb begin
    rot_req = '0;
    off     = '0;
    found   = 1'b0;
    // Rotate so bit 0 is the requester at ptr, then pick the lowest set bit.
    for (int i = 0; i < N_REQ; i++) begin
      rot_req[i] = req[ID_W'((int'(ptr) + i) % N_REQ)];
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && rot_req[i]) begin
        found = 1'b1;
        off   = ID_W'(i);
      end
    end
    id  = ID_W'((int'(ptr) + int'(off)) % N_REQ);
    any = |req;
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
      assign grant[gi] = any & (id == ID_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/satd_job_sched.sv
// Sequencer for the shared 4x4 SATD datapath: round-robin job arbitration,
// LOAD/HT/VT/ACC phase FSM and registered control/status outputs.
module satd_job_sched
  import satd_job_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int PHASE_LEN = PHASE_LEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  satd_job_sched_if.slave bus
);

  localparam logic [2:0] LAST_CNT = 3'(PHASE_LEN - 1);

  state_t           state_q, state_d;
  logic [2:0]       count_q, count_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [OS_W-1:0]  out_signal_q, out_signal_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [N_REQ-1:0] arb_grant;
  logic [ID_W-1:0]  arb_id;
  logic             arb_any;
  logic [ID_W-1:0]  next_ptr;

  satd_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req   (bus.req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .id    (arb_id),
    .any   (arb_any)
  );

  assign next_ptr = ID_W'((int'(arb_id) + 1) % N_REQ);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;

    case (state_q)
      // Both IDLE and ACC are arbitration points; ACC chains straight into
      // the next job so a busy datapath never sees an idle bubble.
      ST_IDLE, ST_ACC: begin
        count_d = '0;
        if (arb_any) begin
          state_d    = ST_LOAD;
          grant_d    = arb_grant;
          grant_id_d = arb_id;
          ptr_d      = next_ptr;
        end else begin
          state_d    = ST_IDLE;
          grant_d    = '0;
          grant_id_d = '0;
        end
      end
      ST_LOAD, ST_HT, ST_VT: begin
        if (count_q == LAST_CNT) begin
          count_d = '0;
          case (state_q)
            ST_LOAD: state_d = ST_HT;
            ST_HT:   state_d = ST_VT;
            default: state_d = ST_ACC;
          endcase
        end else begin
          count_d = count_q + 3'd1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        count_d    = '0;
        grant_d    = '0;
        grant_id_d = '0;
      end
    endcase

    // Outputs are decoded from the next state so the registers line up
    // exactly with state_q/count_q.
    out_signal_d = ctrl_word(state_d, count_d);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_ACC);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      grant_q      <= '0;
      grant_id_q   <= '0;
      ptr_q        <= '0;
      out_signal_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      grant_q      <= grant_d;
      grant_id_q   <= grant_id_d;
      ptr_q        <= ptr_d;
      out_signal_q <= out_signal_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.out_signal = out_signal_q;
  assign bus.state      = state_q;
  assign bus.count      = count_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_satd_job_sched.sv
// Scoreboarded bench for satd_job_sched: expected grants are queued when
// requests are driven and retired on each done pulse.
module tb_satd_job_sched;

  localparam int N_REQ     = 4;
  localparam int ID_W      = 2;
  localparam int PHASE_LEN = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  satd_job_sched_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  satd_job_sched #(
    .N_REQ     (N_REQ),
    .ID_W      (ID_W),
    .PHASE_LEN (PHASE_LEN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [5:0] sb_q[$];   // {grant_id, grant}

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] exp_word(input logic [2:0] s, input logic [2:0] c);
    logic [9:0] w;
    w = '0;
    if (s >= 3'd1 && s <= 3'd3) begin
      w[1:0] = c[1:0];
      w[8]   = 1'b1;
    end
    if (s == 3'd1) begin w[2] = 1'b1; w[6] = (c == 3'd0); end
    if (s == 3'd2) w[3] = 1'b1;
    if (s == 3'd3) begin w[4] = 1'b1; w[5] = 1'b1; end
    if (s == 3'd4) begin w[7] = 1'b1; w[8] = 1'b1; w[9] = 1'b1; end
    return w;
  endfunction

  // Monitor: control word consistency every cycle, scoreboard on done.
  always @(negedge clk) begin
    logic [5:0] e;
    if (!reset) begin
      check_val("ctrl_word", 32'(bus.out_signal), 32'(exp_word(bus.state, bus.count)));
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          check_val("done_unexpected", 32'(bus.grant), 32'(0));
        end else begin
          e = sb_q.pop_front();
          check_val("done_grant", 32'(bus.grant), 32'(e[3:0]));
          check_val("done_id", 32'(bus.grant_id), 32'(e[5:4]));
          $display("done: grant=%b id=%0d", bus.grant, bus.grant_id);
        end
      end
    end
  end

  // Called just after the arbitration edge; walks the 13 cycles of one job.
  task automatic expect_job(input logic [3:0] g, input logic [1:0] id, input int drop_k);
    logic [2:0] es, ec;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      es = (k < 4) ? 3'd1 : (k < 8) ? 3'd2 : (k < 12) ? 3'd3 : 3'd4;
      ec = (k < 12) ? 3'(k % 4) : 3'd0;
      check_val("job_state", 32'(bus.state), 32'(es));
      check_val("job_count", 32'(bus.count), 32'(ec));
      check_val("job_grant", 32'(bus.grant), 32'(g));
      check_val("job_id", 32'(bus.grant_id), 32'(id));
      check_val("job_busy", 32'(bus.busy), 32'(1));
      check_val("job_done", 32'(bus.done), 32'(k == 12));
      if (k == 0)  check_val("load0_word", 32'(bus.out_signal), 32'h144);
      if (k == 12) check_val("acc_word", 32'(bus.out_signal), 32'h380);
      if (k == drop_k) bus.req = '0;
    end
    $display("job: grant=%b id=%0d", g, id);
  endtask

  task automatic expect_idle(input string tag);
    check_val(tag, 32'({bus.state, bus.count, bus.grant, bus.busy, bus.done, bus.out_signal}), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset held with all requests raised: nothing may be granted.
    bus.req = 4'b1111;
    reset   = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      expect_idle("reset_outputs");
      check_val("reset_id", 32'(bus.grant_id), 32'(0));
    end
    bus.req = '0;
    @(posedge clk); #1 reset = 1'b0;

    // Single one-cycle request from requester 2.
    @(posedge clk); #1 bus.req = 4'b0100;
    sb_q.push_back({2'd2, 4'b0100});
    @(posedge clk); #1 bus.req = '0;
    expect_job(4'b0100, 2'd2, -1);
    @(negedge clk);
    expect_idle("idle_after_single");

    // Pointer now sits at 3: 1000 wins over 0001, then 0001 follows.
    @(posedge clk); #1 bus.req = 4'b1001;
    sb_q.push_back({2'd3, 4'b1000});
    sb_q.push_back({2'd0, 4'b0001});
    @(posedge clk); #1;
    expect_job(4'b1000, 2'd3, -1);
    expect_job(4'b0001, 2'd0, 12);
    @(negedge clk);
    expect_idle("idle_after_pair");

    // Reset the pointer, then all four requesters held.
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    expect_idle("reset_mid_bench");
    bus.req = 4'b1111;
    sb_q.push_back({2'd0, 4'b0001});
    sb_q.push_back({2'd1, 4'b0010});
    sb_q.push_back({2'd2, 4'b0100});
    sb_q.push_back({2'd3, 4'b1000});
    sb_q.push_back({2'd0, 4'b0001});
    @(posedge clk); #1;
    expect_job(4'b0001, 2'd0, -1);
    expect_job(4'b0010, 2'd1, -1);
    expect_job(4'b0100, 2'd2, -1);
    expect_job(4'b1000, 2'd3, -1);
    expect_job(4'b0001, 2'd0, 12);
    @(negedge clk);
    expect_idle("idle_after_rr");

    // Request dropped during LOAD count 1: job completes, nothing follows.
    @(posedge clk); #1 bus.req = 4'b0010;
    sb_q.push_back({2'd1, 4'b0010});
    @(posedge clk); #1;
    expect_job(4'b0010, 2'd1, 1);
    repeat (3) begin
      @(negedge clk);
      expect_idle("no_second_grant");
    end

    // Asynchronous reset in HT count 2 kills the job immediately.
    @(posedge clk); #1 bus.req = 4'b0001;
    @(posedge clk); #1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    check_val("pre_reset_state", 32'(bus.state), 32'(2));
    check_val("pre_reset_count", 32'(bus.count), 32'(2));
    reset = 1'b1;
    #1;
    expect_idle("async_reset");
    check_val("async_reset_id", 32'(bus.grant_id), 32'(0));
    @(posedge clk); #1 reset = 1'b0;
    sb_q.push_back({2'd0, 4'b0001});
    @(posedge clk); #1;
    expect_job(4'b0001, 2'd0, 12);
    @(negedge clk);
    expect_idle("idle_after_restart");

    check_val("scoreboard_empty", 32'(sb_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
